// File: rtl/responder_resolver.sv
// responder_resolver: snapshots the tag vector on start and hands out the set
// tags one per valid/ready handshake, lowest word index first, as binary word
// addresses. It also reports whether any responder existed and how many were
// accepted.
module responder_resolver #(
    parameter int WORDS = 100,
    parameter int IDX_W = 7,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WORDS-1:0] tags,
    input  logic             start,
    input  logic             abort,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    output logic             some_none,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

    state_t           state, state_nxt;
    logic [WORDS-1:0] pending;
    logic [WORDS-1:0] pending_rest;
    logic             xfer;

    // Priority encoder: index of the lowest set bit, 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest(input logic [WORDS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = WORDS - 1; i >= 0; i--)
            if (v[i]) r = IDX_W'(i);
        return r;
    endfunction

    // Next state plus handshake decode. The presented index is always the lowest
    // pending bit, so clearing that bit is x & (x-1).
    always_comb begin
        state_nxt    = state;
        xfer         = (state == ISSUE) && idx_valid && idx_ready;
        pending_rest = pending & (pending - WORDS'(1));
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (abort || (pending == '0) || (xfer && (pending_rest == '0)))
                         state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register. Reset drops any enumeration in flight without a done pulse.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Snapshot, responder issue, counter and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending   <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            some_none <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            // done is high for the single cycle spent in FINISH
            done <= (state_nxt == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        pending   <= tags;
                        idx       <= lowest(tags);
                        idx_valid <= |tags;
                        some_none <= |tags;
                        count     <= '0;
                        busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        // abort wins over a simultaneous transfer; nothing is counted
                        pending   <= '0;
                        idx_valid <= 1'b0;
                    end else if (xfer) begin
                        pending   <= pending_rest;
                        idx       <= lowest(pending_rest);
                        idx_valid <= |pending_rest;
                        if (count != '1) count <= count + CNT_W'(1);
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                end
                default: begin
                    pending   <= '0;
                    idx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_responder_resolver.sv
// Testbench for responder_resolver: randomized and directed enumerations,
// scoreboard of expected word indices, final counts and presence flags.
module tb_responder_resolver;

    localparam int WORDS = 100;
    localparam int IDX_W = 7;
    localparam int CNT_W = 8;
    localparam int GUARD = 1000;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WORDS-1:0] tags;
    logic             start;
    logic             abort;
    logic             idx_ready;
    logic [IDX_W-1:0] idx;
    logic             idx_valid;
    logic             some_none;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    responder_resolver #(.WORDS(WORDS), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .tags(tags), .start(start), .abort(abort),
        .idx_ready(idx_ready), .idx(idx), .idx_valid(idx_valid),
        .some_none(some_none), .busy(busy), .done(done), .count(count)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // scoreboard
    int exp_q[$];
    int cnt_q[$];
    bit sn_q[$];
    int done_cyc;
    int done_seen;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [WORDS-1:0] rand_tags(input int dens);
        logic [WORDS-1:0] v;
        for (int i = 0; i < WORDS; i++) v[i] = ($urandom_range(0, 99) < dens);
        return v;
    endfunction

    // monitor: checks every accepted index, stall stability and each done pulse
    bit               p_v, p_r, p_a;
    logic [IDX_W-1:0] p_idx;
    always @(negedge CLK) begin
        if (RST) begin
            p_v = 1'b0;
        end else begin
            if (p_v && !p_r && !p_a) begin
                chk("stall_valid", idx_valid, 1);
                chk("stall_idx", idx, p_idx);
            end
            if (idx_valid) chk("idx_range", int'(idx) < WORDS, 1);
            if (idx_valid && idx_ready && !abort) begin
                if (exp_q.size() == 0) chk("spurious_idx", idx, -1);
                else                   chk("idx", idx, exp_q.pop_front());
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                if (cnt_q.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    chk("done_count", count, cnt_q.pop_front());
                    chk("done_some_none", some_none, sn_q.pop_front());
                    chk("done_no_valid", idx_valid, 0);
                end
            end
            p_v   = idx_valid;
            p_r   = idx_ready;
            p_a   = abort;
            p_idx = idx;
        end
    end

    // One enumeration. Called at #1 after a rising edge with the DUT idle.
    // mode 0: ready held high, 1: random ready, 2: ready pattern 1,0,0,1,1 then 1.
    // abort_k >= 0: abort once abort_k responders were accepted.
    // stray: pulse start again two cycles into the enumeration.
    task automatic run(input logic [WORDS-1:0] tv, input int mode, input int abort_k,
                       input bit stray);
        int lst[$];
        int n, k, cs, pat_i, guard, exp_cnt;
        bit aborted;
        bit pat[5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < WORDS; i++) if (tv[i]) lst.push_back(i);
        n       = lst.size();
        exp_cnt = (abort_k >= 0) ? abort_k : n;
        foreach (lst[i]) exp_q.push_back(lst[i]);
        cnt_q.push_back(exp_cnt);
        sn_q.push_back(n != 0);
        done_seen = 0;

        start = 1'b1;
        tags  = tv;
        cs    = cyc;
        @(posedge CLK); #1;
        start = 1'b0;
        tags  = rand_tags(50);   // later tag changes must not leak in
        chk("first_valid", idx_valid, n != 0);
        if (n != 0) chk("first_idx", idx, lst[0]);
        chk("busy_after_start", busy, 1);

        k = 0; pat_i = 0; guard = 0; aborted = 1'b0;
        while (busy && guard < GUARD) begin
            abort = 1'b0;
            case (mode)
                0:       idx_ready = 1'b1;
                1:       idx_ready = $urandom_range(0, 1);
                default: idx_ready = (pat_i < 5) ? pat[pat_i] : 1'b1;
            endcase
            if (abort_k >= 0 && !aborted && k == abort_k && idx_valid) begin
                abort     = 1'b1;
                idx_ready = 1'b1;
                aborted   = 1'b1;
            end else if (idx_valid && idx_ready) begin
                k++;
            end
            if (stray && pat_i == 2) begin
                start = 1'b1;
                tags  = rand_tags(50);
            end else begin
                start = 1'b0;
            end
            pat_i++;
            guard++;
            @(posedge CLK); #1;
            if (abort) begin
                exp_q.delete();
                abort = 1'b0;
            end
        end
        start     = 1'b0;
        idx_ready = 1'b0;
        abort     = 1'b0;
        chk("busy_timeout", guard < GUARD, 1);
        chk("done_pulses", done_seen, 1);
        if (mode == 0 && abort_k < 0) chk("done_cycle", done_cyc, cs + ((n != 0) ? n + 1 : 2));
        chk("count_hold", count, exp_cnt);
        chk("some_none_hold", some_none, n != 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_valid", idx_valid, 0);
        repeat ($urandom_range(0, 2)) @(posedge CLK);
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WORDS-1:0] tv;
        int n, dens, ak;
        RST = 1'b1; start = 1'b0; abort = 1'b0; idx_ready = 1'b0; tags = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_idx", idx, 0);
        chk("rst_valid", idx_valid, 0);
        chk("rst_some_none", some_none, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // empty snapshot
        run('0, 0, -1, 1'b0);

        // {3,17,99} with ready held, then with stalls
        tv = '0; tv[3] = 1'b1; tv[17] = 1'b1; tv[99] = 1'b1;
        run(tv, 0, -1, 1'b0);
        run(tv, 2, -1, 1'b0);

        // every word responds
        run('1, 0, -1, 1'b0);

        // abort while idx=6, plus an ignored second start
        tv = '0; tv[5] = 1'b1; tv[6] = 1'b1; tv[7] = 1'b1;
        run(tv, 0, 1, 1'b1);

        // reset in the middle of an enumeration
        tv = '0; tv[3] = 1'b1; tv[17] = 1'b1; tv[99] = 1'b1;
        exp_q.push_back(3);
        start = 1'b1; tags = tv;
        @(posedge CLK); #1;
        start = 1'b0; idx_ready = 1'b1;
        @(posedge CLK); #1;
        idx_ready = 1'b0;
        chk("pre_rst_idx", idx, 17);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_q.delete();
        chk("mid_rst_idx", idx, 0);
        chk("mid_rst_valid", idx_valid, 0);
        chk("mid_rst_some_none", some_none, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_count", count, 0);
        @(posedge CLK); #1;
        chk("post_rst_done", done, 0);
        tv = '0; tv[0] = 1'b1;
        run(tv, 0, -1, 1'b0);

        // randomized enumerations
        for (int r = 0; r < 30; r++) begin
            case ($urandom_range(0, 4))
                0:       dens = 0;
                1:       dens = 3;
                2:       dens = 15;
                3:       dens = 50;
                default: dens = 100;
            endcase
            tv = rand_tags(dens);
            n  = $countones(tv);
            ak = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run(tv, $urandom_range(0, 2), ak, $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
